// File: rtl/dbg_pc_trace_pkg.sv
// Shared types for the PC trace monitor: FSM state encoding and depth helper.
package dbg_pc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_t;

  function automatic int depth_of(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/dbg_pc_trace_if.sv
// Debug-tree side bundle of the PC trace monitor: strobes, trigger setup and readout.
interface dbg_pc_trace_if #(
  parameter int PC_WIDTH   = 18,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_CMP    = 2
);
  logic                        clken;
  logic                        loadIR;
  logic                        loadVMA;
  logic [PC_WIDTH-1:0]         pcIN;
  logic [NUM_CMP*PC_WIDTH-1:0] cmpADDR;
  logic [NUM_CMP-1:0]          cmpEN;
  logic                        arm;
  logic                        clear;
  logic [DEPTH_LOG2-1:0]       rdIDX;
  logic [PC_WIDTH-1:0]         rdDATA;
  logic [DEPTH_LOG2:0]         count;
  logic [PC_WIDTH-1:0]         lastPC;
  logic [NUM_CMP-1:0]          trigHIT;
  logic                        frozen;
  logic                        pcSTALL;
  logic                        pcSTUCK;

  modport master (
    output clken, loadIR, loadVMA, pcIN, cmpADDR, cmpEN, arm, clear, rdIDX,
    input  rdDATA, count, lastPC, trigHIT, frozen, pcSTALL, pcSTUCK
  );

  modport slave (
    input  clken, loadIR, loadVMA, pcIN, cmpADDR, cmpEN, arm, clear, rdIDX,
    output rdDATA, count, lastPC, trigHIT, frozen, pcSTALL, pcSTUCK
  );
endinterface

// File: rtl/dbg_pc_trace_ram.sv
// Trace storage: simple dual-port RAM, synchronous write, registered read (old data on collision).
module dbg_trace_ram #(
  parameter int AW = 4,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dbg_pc_trace.sv
// PC history buffer with address trigger/freeze plus IR/VMA watchdogs for stuck-CPU detection.
//   state  | meaning
//   IDLE   | recording, trigger disarmed
//   ARMED  | recording, comparators live
//   POST   | recording post-trigger entries
//   FROZEN | buffer held until re-armed or cleared
module dbg_pc_trace
  import dbg_pc_trace_pkg::*;
#(
  parameter int PC_WIDTH   = 18,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_CMP    = 2,
  parameter int POST_TRIG  = 4,
  parameter int TIMEOUT    = 2**20,
  parameter int TMO_WIDTH  = 21
) (
  input logic           clk,
  input logic           rst,
  dbg_pc_trace_if.slave bus
);

  localparam int DEPTH = depth_of(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(POST_TRIG);
  localparam logic [TMO_WIDTH-1:0]  TMO = TMO_WIDTH'(TIMEOUT);

  trace_state_t          state, state_nxt;
  logic [DEPTH_LOG2-1:0] post_cnt, post_nxt;
  logic [NUM_CMP-1:0]    hit_q, hit_nxt, match;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_addr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  we;
  logic                  rd_ok;
  logic [PC_WIDTH-1:0]   ram_q, last_pc;
  logic [TMO_WIDTH-1:0]  ir_cnt, vma_cnt;
  logic                  stall_q, stuck_q;

  for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
    assign match[gi] = bus.cmpEN[gi] &&
                       (bus.pcIN == bus.cmpADDR[gi*PC_WIDTH +: PC_WIDTH]);
  end

  always_comb begin
    state_nxt = state;
    post_nxt  = post_cnt;
    hit_nxt   = hit_q;
    we        = 1'b0;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
      post_nxt  = '0;
      hit_nxt   = '0;
    end else if (bus.clken) begin
      we = bus.loadIR && (state != ST_FROZEN);
      unique case (state)
        ST_IDLE, ST_FROZEN: begin
          if (bus.arm) begin
            state_nxt = ST_ARMED;
            hit_nxt   = '0;
          end
        end
        ST_ARMED: begin
          if (bus.loadIR && (|match)) begin
            hit_nxt = hit_q | match;
            if (POST_TRIG == 0) begin
              state_nxt = ST_FROZEN;
            end else begin
              state_nxt = ST_POST;
              post_nxt  = POST_INIT;
            end
          end
        end
        ST_POST: begin
          if (bus.loadIR) begin
            post_nxt = post_cnt - DEPTH_LOG2'(1);
            if (post_cnt == DEPTH_LOG2'(1)) state_nxt = ST_FROZEN;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      post_cnt <= '0;
      hit_q    <= '0;
    end else begin
      state    <= state_nxt;
      post_cnt <= post_nxt;
      hit_q    <= hit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (we) begin
      wr_ptr  <= wr_ptr + DEPTH_LOG2'(1);
      if (count_q != FULL) count_q <= count_q + (DEPTH_LOG2+1)'(1);
    end
  end

  // Index 0 is the newest entry; pointer and count are pre-write, so a
  // concurrent capture is not visible until the following read.
  assign rd_addr = wr_ptr - DEPTH_LOG2'(1) - bus.rdIDX;

  always_ff @(posedge clk) begin
    if (rst) rd_ok <= 1'b0;
    else     rd_ok <= ({1'b0, bus.rdIDX} < count_q);
  end

  dbg_trace_ram #(.AW(DEPTH_LOG2), .DW(PC_WIDTH)) u_ram (
    .clk   (clk),
    .we    (we && !rst),
    .waddr (wr_ptr),
    .wdata (bus.pcIN),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst)                           last_pc <= '0;
    else if (bus.clken && bus.loadIR)  last_pc <= bus.pcIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_cnt  <= '0;
      vma_cnt <= '0;
    end else if (bus.clken) begin
      if (bus.loadIR)       ir_cnt <= '0;
      else if (ir_cnt < TMO) ir_cnt <= ir_cnt + TMO_WIDTH'(1);
      if (bus.loadVMA)        vma_cnt <= '0;
      else if (vma_cnt < TMO) vma_cnt <= vma_cnt + TMO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      stall_q <= (ir_cnt >= TMO) && (vma_cnt < TMO);
      stuck_q <= (ir_cnt >= TMO) && (vma_cnt >= TMO);
    end
  end

  assign bus.rdDATA  = rd_ok ? ram_q : '0;
  assign bus.count   = count_q;
  assign bus.lastPC  = last_pc;
  assign bus.trigHIT = hit_q;
  assign bus.frozen  = (state == ST_FROZEN);
  assign bus.pcSTALL = stall_q;
  assign bus.pcSTUCK = stuck_q;

endmodule

// File: tb/tb_dbg_pc_trace.sv
// Directed bench: two monitors (post-trigger 4 and 0) share stimulus; reads go through a scoreboard.
module tb_dbg_pc_trace;

  localparam logic [17:0] TRIG = 18'o030057;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        clken, loadIR, loadVMA, arm, clear;
  logic [17:0] pcIN;
  logic [35:0] cmpADDR;
  logic [1:0]  cmpEN;
  logic [3:0]  rdIDX;

  dbg_pc_trace_if #(.PC_WIDTH(18), .DEPTH_LOG2(4), .NUM_CMP(2)) bus_a ();
  dbg_pc_trace_if #(.PC_WIDTH(18), .DEPTH_LOG2(4), .NUM_CMP(2)) bus_b ();

  assign bus_a.clken = clken;   assign bus_b.clken = clken;
  assign bus_a.loadIR = loadIR; assign bus_b.loadIR = loadIR;
  assign bus_a.loadVMA = loadVMA; assign bus_b.loadVMA = loadVMA;
  assign bus_a.pcIN = pcIN;     assign bus_b.pcIN = pcIN;
  assign bus_a.cmpADDR = cmpADDR; assign bus_b.cmpADDR = cmpADDR;
  assign bus_a.cmpEN = cmpEN;   assign bus_b.cmpEN = cmpEN;
  assign bus_a.arm = arm;       assign bus_b.arm = arm;
  assign bus_a.clear = clear;   assign bus_b.clear = clear;
  assign bus_a.rdIDX = rdIDX;   assign bus_b.rdIDX = rdIDX;

  dbg_pc_trace #(.PC_WIDTH(18), .DEPTH_LOG2(4), .NUM_CMP(2), .POST_TRIG(4),
                 .TIMEOUT(64), .TMO_WIDTH(7)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dbg_pc_trace #(.PC_WIDTH(18), .DEPTH_LOG2(4), .NUM_CMP(2), .POST_TRIG(0),
                 .TIMEOUT(64), .TMO_WIDTH(7)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] q_a[$];
  logic [17:0] q_b[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [17:0] pc);
    loadIR = 1'b1; pcIN = pc;
    tick();
    loadIR = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [17:0] ea, input logic [17:0] eb);
    rdIDX = idx;
    q_a.push_back(ea);
    q_b.push_back(eb);
    tick();
    chk($sformatf("rd_a[%0d]", idx), bus_a.rdDATA, q_a.pop_front());
    chk($sformatf("rd_b[%0d]", idx), bus_b.rdDATA, q_b.pop_front());
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; loadIR = 1'b0; loadVMA = 1'b0; arm = 1'b0; clear = 1'b0;
    pcIN = '0; cmpADDR = '0; cmpEN = '0; rdIDX = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count", bus_a.count, 0);
    chk("rst_rdDATA", bus_a.rdDATA, 0);
    chk("rst_lastPC", bus_a.lastPC, 0);
    chk("rst_flags", {bus_a.trigHIT, bus_a.frozen, bus_a.pcSTALL, bus_a.pcSTUCK}, 0);

    // Depth wrap
    for (int i = 1; i <= 20; i++) capture(18'(i));
    chk("wrap_count", bus_a.count, 16);
    chk("wrap_lastPC", bus_a.lastPC, 20);
    rd(4'd0, 18'd20, 18'd20);
    rdIDX = 4'd15;
    chk("rd_latency_hold", bus_a.rdDATA, 20);
    q_a.push_back(18'd5);
    tick();
    chk("rd_latency_new", bus_a.rdDATA, q_a.pop_front());

    // Trigger and post-capture
    cmpADDR = {18'o777777, TRIG}; cmpEN = 2'b01;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 100; i <= 105; i++) capture(18'(i));
    capture(TRIG);
    chk("b_frozen_on_trig", bus_b.frozen, 1);
    chk("a_not_frozen_on_trig", bus_a.frozen, 0);
    for (int i = 200; i <= 202; i++) capture(18'(i));
    chk("a_not_frozen_202", bus_a.frozen, 0);
    capture(18'd203);
    chk("a_frozen_203", bus_a.frozen, 1);
    for (int i = 204; i <= 209; i++) capture(18'(i));
    chk("a_trigHIT", bus_a.trigHIT, 2'b01);
    chk("b_trigHIT", bus_b.trigHIT, 2'b01);
    chk("a_lastPC", bus_a.lastPC, 209);
    chk("a_count_frozen", bus_a.count, 16);
    rd(4'd0, 18'd203, TRIG);
    rd(4'd4, TRIG, 18'd102);

    // clear beats arm
    clear = 1'b1; arm = 1'b1; tick(); clear = 1'b0; arm = 1'b0;
    chk("clr_count_a", bus_a.count, 0);
    chk("clr_count_b", bus_b.count, 0);
    chk("clr_hit_frz_a", {bus_a.trigHIT, bus_a.frozen}, 0);
    chk("clr_hit_frz_b", {bus_b.trigHIT, bus_b.frozen}, 0);
    chk("clr_keeps_lastPC", bus_a.lastPC, 209);
    capture(TRIG); capture(18'd7); capture(18'd8);
    chk("idle_no_trig_a", {bus_a.trigHIT, bus_a.frozen}, 0);
    chk("idle_no_trig_b", {bus_b.trigHIT, bus_b.frozen}, 0);
    chk("count3", bus_a.count, 3);

    // Read bounds and read-during-write
    rd(4'd7, 18'd0, 18'd0);
    rd(4'd2, TRIG, TRIG);
    rd(4'd0, 18'd8, 18'd8);
    rdIDX = 4'd0; loadIR = 1'b1; pcIN = 18'd9;
    q_a.push_back(18'd8);
    tick();
    loadIR = 1'b0;
    chk("rd_pre_write", bus_a.rdDATA, q_a.pop_front());
    chk("count4", bus_a.count, 4);

    // clken gating
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin capture(18'h55); tick(); end
    chk("gated_count", bus_a.count, 4);
    chk("gated_lastPC", bus_a.lastPC, 9);
    clken = 1'b1;

    // rst during POST
    arm = 1'b1; tick(); arm = 1'b0;
    capture(TRIG); capture(18'd300);
    chk("post_hit", bus_a.trigHIT, 2'b01);
    chk("post_not_frozen", bus_a.frozen, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstpost_count", bus_a.count, 0);
    chk("rstpost_state", {bus_a.trigHIT, bus_a.frozen, bus_b.frozen}, 0);
    chk("rstpost_lastPC", bus_a.lastPC, 0);
    chk("rstpost_rdDATA", bus_a.rdDATA, 0);
    capture(TRIG);
    for (int i = 1; i <= 4; i++) capture(18'(i));
    chk("rstpost_idle", {bus_a.trigHIT, bus_a.frozen, bus_b.frozen}, 0);
    chk("rstpost_count5", bus_a.count, 5);

    // Watchdogs
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 70; i++) begin
      loadVMA = (i % 10 == 0);
      tick();
    end
    loadVMA = 1'b0;
    chk("wd_stall", {bus_a.pcSTALL, bus_a.pcSTUCK}, 2'b10);
    for (int i = 0; i < 70; i++) tick();
    chk("wd_stuck", {bus_a.pcSTALL, bus_a.pcSTUCK}, 2'b01);
    loadVMA = 1'b1; tick(); loadVMA = 1'b0;
    tick();
    chk("wd_stuck_to_stall", {bus_a.pcSTALL, bus_a.pcSTUCK}, 2'b10);
    loadIR = 1'b1; pcIN = 18'd1; tick(); loadIR = 1'b0;
    chk("wd_flag_registered", {bus_a.pcSTALL, bus_a.pcSTUCK}, 2'b10);
    tick();
    chk("wd_clear", {bus_a.pcSTALL, bus_a.pcSTUCK}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
